// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10
  } state_e;

  function automatic logic is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_e              op,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd};
    acc_nxt = acc;
    if (is_div(op)) begin
      // Remainder lives in the upper half, quotient bits shift in at the bottom.
      if (!diff[WIDTH]) acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      // Carry of the partial sum becomes the new top bit after the shift.
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative mult/div unit with start/busy/done handshake and flush cancel.
// MDU_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e              state;
  mdu_op_e             op_q;
  mdu_op_e             op_in;
  logic                sign_q, sign_r, bz_q;
  logic [WIDTH-1:0]    a_q, opnd;
  logic [2*WIDTH-1:0]  acc, step_acc, prod;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                in_signed, last_step;
  logic [WIDTH-1:0]    amag, bmag, quo, rem;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (step_acc)
  );

  always_comb begin
    op_in     = mdu_op_e'(op);
    in_signed = is_signed_op(op_in);
    amag      = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    bmag      = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    cnt_nxt   = cnt + CNT_W'(1);
    last_step = (cnt_nxt == CNT_W'(WIDTH));
`ifdef MDU_EARLY_TERM_EN
    // Low WIDTH-cnt_nxt bits still hold the unconsumed multiplier.
    if (!is_div(op_q) && ((step_acc[WIDTH-1:0] & ({WIDTH{1'b1}} >> cnt_nxt)) == '0))
      last_step = 1'b1;
    prod = acc >> (CNT_W'(WIDTH) - cnt);
`else
    prod = acc;
`endif
    if (sign_q) prod = ~prod + 1'b1;
    quo = sign_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem = sign_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      op_q        <= MDU_MULT;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      bz_q        <= 1'b0;
      a_q         <= '0;
      opnd        <= '0;
      acc         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            op_q   <= op_in;
            a_q    <= a;
            bz_q   <= (b == '0);
            sign_q <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r <= in_signed & a[WIDTH-1];
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
            if (is_div(op_in)) begin
              acc  <= {{WIDTH{1'b0}}, amag};
              opnd <= bmag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, bmag};
              opnd <= amag;
            end
`ifdef MDU_EARLY_TERM_EN
            if (!is_div(op_in) && (bmag == '0)) state <= SIGN;
`endif
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= step_acc;
            cnt <= cnt_nxt;
            if (last_step) state <= SIGN;
          end
        end
        SIGN: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
            if (!is_div(op_q)) begin
              {hi, lo} <= prod;
            end else if (bz_q) begin
              lo          <= '1;
              hi          <= a_q;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem;
              lo <= quo;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
